// File: rtl/i2s_rx.sv
// I2S master receiver for an ICS-43432 style microphone.
// Generates bclk/lr_clk from clk, synchronises the serial data, and returns
// the upper 16 bits of the selected channel once per frame with a one-cycle
// valid pulse. A configurable number of whole frames is dropped after each
// enable so the mic can settle before samples are emitted.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | en low (or first enabled cycle); discard count reloaded
// ST_DISCARD | clocks running, counting down whole frames, no capture
// ST_RUN     | running=1, selected channel captured every frame
module i2s_rx #(
  parameter int CAPTURE_CH     = 1,
  parameter int DISCARD_FRAMES = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  bclk_period,
  input  logic        sd,
  output logic        bclk,
  output logic        lr_clk,
  output logic        sample_vld,
  output logic [15:0] sample,
  output logic        running
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DISCARD = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam logic [7:0] DISC_INIT = 8'(DISCARD_FRAMES);
  localparam logic       CAP_LR    = (CAPTURE_CH != 0);

  logic [7:0]             p_eff;
  logic [7:0]             ccnt;
  logic [6:0]             hcnt;
  logic [4:0]             slot;
  logic                   half_end;
  logic                   strobe;
  logic                   frame_end;
  logic                   capture;
  logic                   word_end;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   sd_s;
  logic [15:0]            shift;
  state_t                 state;
  state_t                 state_nxt;
  logic [7:0]             disc_cnt;
  logic [7:0]             disc_nxt;

  // Half periods shorter than 4 clk leave too little margin for the
  // synchroniser, so they are clamped up.
  assign p_eff    = (bclk_period < 8'd4) ? 8'd4 : bclk_period;
  assign half_end = (ccnt == p_eff - 8'd1);

  // bclk and lr_clk come straight from the half-period counter bits.
  assign bclk   = hcnt[0];
  assign lr_clk = hcnt[6];
  assign slot   = hcnt[5:1];

  // Sample point is the last clk of bclk high, just before the mic shifts.
  assign strobe    = en & half_end & hcnt[0];
  assign frame_end = en & half_end & (hcnt == 7'd127);
  // Slot 0 is the I2S one-bit delay; slots 1..16 carry D23..D8.
  assign capture   = strobe & running & (lr_clk == CAP_LR) &
                     (slot != 5'd0) & (slot <= 5'd16);
  assign word_end  = capture & (slot == 5'd16);

  assign sd_s    = sd_sync[SYNC_STAGES-1];
  assign running = (state == ST_RUN);

  // Clock divider and half-period counter; both restart at frame start on enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccnt <= '0;
      hcnt <= '0;
    end else if (!en) begin
      ccnt <= '0;
      hcnt <= '0;
    end else if (half_end) begin
      ccnt <= '0;
      hcnt <= hcnt + 7'd1;
    end else begin
      ccnt <= ccnt + 8'd1;
    end
  end

  // Multi-flop synchroniser for the asynchronous mic data line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_sync <= '0;
    end else begin
      sd_sync <= {sd_sync[SYNC_STAGES-2:0], sd};
    end
  end

  // Deserialiser; a partial word is thrown away when en drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
    end else if (!en) begin
      shift <= '0;
    end else if (capture) begin
      shift <= {shift[14:0], sd_s};
    end
  end

  // Output word register; holds its value across disable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample <= '0;
    end else if (word_end) begin
      sample <= {shift[14:0], sd_s};
    end
  end

  // Valid pulse accompanies the cycle the new word first appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_vld <= 1'b0;
    end else begin
      sample_vld <= word_end;
    end
  end

  // Start-up state and discard frame counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      disc_cnt <= '0;
    end else begin
      state    <= state_nxt;
      disc_cnt <= disc_nxt;
    end
  end

  // Next-state logic: count down whole frames, then enter run at a frame start.
  always_comb begin
    state_nxt = state;
    disc_nxt  = disc_cnt;
    if (!en) begin
      state_nxt = ST_IDLE;
      disc_nxt  = DISC_INIT;
    end else begin
      case (state)
        ST_IDLE: begin
          disc_nxt  = DISC_INIT;
          state_nxt = (DISCARD_FRAMES == 0) ? ST_RUN : ST_DISCARD;
        end
        ST_DISCARD: begin
          if (frame_end) begin
            if (disc_cnt <= 8'd1) begin
              state_nxt = ST_RUN;
              disc_nxt  = '0;
            end else begin
              disc_nxt = disc_cnt - 8'd1;
            end
          end
        end
        ST_RUN: begin
          state_nxt = ST_RUN;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: two instances (right channel / no discard, and left
// channel / two discard frames / three sync flops) share one mic model.
// The reference tracks how many enabled clk edges have elapsed and derives
// every expected output from frame arithmetic.
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  bclk_period;
  logic        sd = 1'b0;

  logic        bclk_a, lr_a, vld_a, run_a;
  logic [15:0] sample_a;
  logic        bclk_b, lr_b, vld_b, run_b;
  logic [15:0] sample_b;

  logic [23:0] word_l = '0;
  logic [23:0] word_r = '0;
  logic        fill = 1'b0;
  logic        fill_hi = 1'b0;

  int checks = 0;
  int passed = 0;

  int n = 0;
  logic [15:0] exp_sa = '0;
  logic [15:0] exp_sb = '0;
  int cnt_a = 0, cnt_b = 0, tot_a = 0, hi_a = 0;
  int first_a = -1, first_b = -1, prev_a = 0, last_a = 0;
  int tot0;

  i2s_rx #(.CAPTURE_CH(1), .DISCARD_FRAMES(0), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .bclk_period(bclk_period), .sd(sd),
    .bclk(bclk_a), .lr_clk(lr_a), .sample_vld(vld_a), .sample(sample_a),
    .running(run_a)
  );

  i2s_rx #(.CAPTURE_CH(0), .DISCARD_FRAMES(2), .SYNC_STAGES(3)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .bclk_period(bclk_period), .sd(sd),
    .bclk(bclk_b), .lr_clk(lr_b), .sample_vld(vld_b), .sample(sample_b),
    .running(run_b)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int peff(input logic [7:0] b);
    return (b < 8'd4) ? 4 : int'(b);
  endfunction

  // After nn enabled edges, does the word for channel ch complete now?
  // The slot-16 sample point is the last clk of half period 33 (left) or
  // 97 (right); frames before d are discarded.
  function automatic bit xvld(input int nn, input int p, input int d, input int ch);
    int fl;
    int hs;
    fl = 128 * p;
    hs = (ch != 0) ? 97 : 33;
    return (nn >= 1) && ((nn % fl) == (hs + 1) * p) && (((nn - 1) / fl) >= d);
  endfunction

  // Mic: slot 0 is fill, slots 1..24 carry the 24-bit word MSB first.
  initial forever begin
    int p2, half, slot;
    logic [23:0] w;
    @(negedge clk);
    p2   = peff(bclk_period);
    half = (n / p2) % 128;
    slot = (half % 64) / 2;
    w    = (half >= 64) ? word_r : word_l;
    if (slot >= 1 && slot <= 24 && !(fill_hi && slot >= 17)) sd = w[24 - slot];
    else sd = fill;
  end

  // Reference model and per-cycle compare.
  initial forever begin
    int p;
    @(posedge clk or negedge rst_n);
    p = peff(bclk_period);
    if (!rst_n) begin
      n = 0;
      exp_sa = '0;
      exp_sb = '0;
    end else begin
      if (en) n++;
      else n = 0;
      if (xvld(n, p, 0, 1)) exp_sa = word_r[23:8];
      if (xvld(n, p, 2, 0)) exp_sb = word_l[23:8];
    end
    #1;
    chk("a_bclk",    32'(bclk_a),   32'((n / p) % 2));
    chk("a_lr",      32'(lr_a),     32'(((n / p) / 64) % 2));
    chk("a_vld",     32'(vld_a),    32'(rst_n && xvld(n, p, 0, 1)));
    chk("a_running", 32'(run_a),    32'(n >= 1));
    chk("a_sample",  32'(sample_a), 32'(exp_sa));
    chk("b_bclk",    32'(bclk_b),   32'((n / p) % 2));
    chk("b_lr",      32'(lr_b),     32'(((n / p) / 64) % 2));
    chk("b_vld",     32'(vld_b),    32'(rst_n && xvld(n, p, 2, 0)));
    chk("b_running", 32'(run_b),    32'(n >= 2 * 128 * p));
    chk("b_sample",  32'(sample_b), 32'(exp_sb));
    if (n == 0) begin
      cnt_a = 0; cnt_b = 0; hi_a = 0;
      first_a = -1; first_b = -1; prev_a = 0; last_a = 0;
    end else begin
      if (bclk_a) hi_a++;
      if (vld_a) begin
        if (first_a < 0) first_a = n;
        prev_a = last_a;
        last_a = n;
        cnt_a++;
        tot_a++;
      end
      if (vld_b) begin
        if (first_b < 0) first_b = n;
        cnt_b++;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    bclk_period = 8'd4;
    repeat (3) @(negedge clk);
    chk("rst_bclk",     32'(bclk_a),   32'd0);
    chk("rst_lr",       32'(lr_a),     32'd0);
    chk("rst_sample",   32'(sample_a), 32'd0);
    chk("rst_vld",      32'(vld_a),    32'd0);
    chk("rst_running",  32'(run_b),    32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic capture, P=4, both channels.
    word_l = 24'h123456;
    word_r = 24'hA5C37E;
    en = 1'b1;
    repeat (2048) @(negedge clk);
    chk("t1_sample_r",  32'(sample_a), 32'h0000A5C3);
    chk("t1_sample_l",  32'(sample_b), 32'h00001234);
    chk("t1_cnt_a",     32'(cnt_a),    32'd4);
    chk("t1_cnt_b",     32'(cnt_b),    32'd2);
    chk("t1_first_a",   32'(first_a),  32'd392);
    chk("t1_first_b",   32'(first_b),  32'd1160);
    chk("t1_interval",  32'(last_a - prev_a), 32'd512);

    // Fill bits high around the payload, right word zero.
    en = 1'b0;
    repeat (4) @(negedge clk);
    word_l = 24'h00FF00;
    word_r = 24'h000000;
    fill = 1'b1;
    fill_hi = 1'b1;
    en = 1'b1;
    repeat (2048) @(negedge clk);
    chk("t2_sample_r",  32'(sample_a), 32'h00000000);
    chk("t2_sample_l",  32'(sample_b), 32'h000000FF);
    chk("t2_cnt_a",     32'(cnt_a),    32'd4);

    // Drop enable during right slot 10.
    en = 1'b0;
    repeat (4) @(negedge clk);
    word_l = 24'h123456;
    word_r = 24'hA5C37E;
    fill = 1'b0;
    fill_hi = 1'b0;
    tot0 = tot_a;
    en = 1'b1;
    repeat (340) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("t3_bclk_off",  32'(bclk_a),   32'd0);
    chk("t3_lr_off",    32'(lr_a),     32'd0);
    chk("t3_no_vld",    32'(tot_a),    32'(tot0));
    chk("t3_hold",      32'(sample_a), 32'h00000000);
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (600) @(negedge clk);
    chk("t3_b_discard", 32'(run_b),    32'd0);
    repeat (936) @(negedge clk);
    chk("t3_cnt_b",     32'(cnt_b),    32'd1);
    chk("t3_first_b",   32'(first_b),  32'd1160);
    chk("t3_sample_l",  32'(sample_b), 32'h00001234);
    chk("t3_cnt_a",     32'(cnt_a),    32'd3);

    // bclk_period below 4 behaves as 4.
    en = 1'b0;
    repeat (4) @(negedge clk);
    bclk_period = 8'd2;
    en = 1'b1;
    repeat (1024) @(negedge clk);
    chk("t4_bclk_high", 32'(hi_a),     32'd512);
    chk("t4_cnt_a",     32'(cnt_a),    32'd2);
    chk("t4_interval",  32'(last_a - prev_a), 32'd512);
    chk("t4_sample_r",  32'(sample_a), 32'h0000A5C3);

    // Asynchronous reset mid-frame clears outputs immediately.
    repeat (100) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_sample_a",  32'(sample_a), 32'd0);
    chk("t5_sample_b",  32'(sample_b), 32'd0);
    chk("t5_bclk",      32'(bclk_a),   32'd0);
    chk("t5_lr",        32'(lr_b),     32'd0);
    chk("t5_running",   32'(run_a),    32'd0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
